// File: rtl/aoi_sweep_ctrl_pkg.sv
// Shared definitions for the AOI gate sweep controller: state encoding,
// vector width and the default expected truth table.
package aoi_sweep_ctrl_pkg;

  localparam int unsigned AOI_VEC_W      = 4;
  localparam logic [15:0] AOI_TT_DEFAULT = 16'h0777;
  localparam logic [3:0]  DWELL_DEFAULT  = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // 1 when a sampled gate bit disagrees with the expected table entry
  function automatic logic bit_mismatch(input logic [15:0] tt, input logic [3:0] idx,
                                        input logic y);
    return (y != tt[idx]);
  endfunction

endpackage

// File: rtl/aoi_sweep_ctrl_aoi4.sv
// Four-input AND-OR-INVERT gate, y = ~((a & b) | (c & d)).
module aoi_sweep_ctrl_aoi4 (
  output logic y,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d
);

  assign y = ~((a & b) | (c & d));

endmodule

// File: rtl/aoi_sweep_ctrl.sv
// Arbitrates a 16-vector self-test sweep and single-vector evaluations onto
// one shared AOI gate, holding each vector DWELL cycles before sampling.
module aoi_sweep_ctrl
  import aoi_sweep_ctrl_pkg::*;
#(
  parameter logic [3:0]  DWELL  = DWELL_DEFAULT,
  parameter logic [15:0] EXP_TT = AOI_TT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 eval_req,
  input  logic [AOI_VEC_W-1:0] eval_vec,
  output logic                 eval_ack,
  output logic                 eval_y,
  output logic [AOI_VEC_W-1:0] vec_o,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          tt_o,
  output logic                 pass,
  output logic [4:0]           err_cnt
);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 sweep_q, sweep_d;
  logic [AOI_VEC_W-1:0] vec_q, vec_d;
  logic [15:0]          tt_q, tt_d;
  logic [4:0]           err_q, err_d;
  logic                 pass_q, pass_d;
  logic                 eval_y_q, eval_y_d;
  logic                 ack_q, ack_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 gate_y;

  aoi_sweep_ctrl_aoi4 u_aoi (
    .y (gate_y),
    .a (vec_q[3]),
    .b (vec_q[2]),
    .c (vec_q[1]),
    .d (vec_q[0])
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_d  = sweep_q;
    vec_d    = vec_q;
    tt_d     = tt_q;
    err_d    = err_q;
    pass_d   = pass_q;
    eval_y_d = eval_y_q;
    ack_d    = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // start wins a tie; a level-held eval_req is picked up once idle again
        if (start) begin
          sweep_d = 1'b1;
          vec_d   = 4'd0;
          tt_d    = 16'd0;
          err_d   = 5'd0;
          pass_d  = 1'b0;
          cnt_d   = DWELL - 4'd1;
          state_d = ST_SETTLE;
        end else if (eval_req) begin
          sweep_d = 1'b0;
          vec_d   = eval_vec;
          cnt_d   = DWELL - 4'd1;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (sweep_q) begin
          tt_d[vec_q] = gate_y;
          err_d = err_q + {4'd0, bit_mismatch(EXP_TT, vec_q, gate_y)};
          if (vec_q == 4'd15) begin
            done_d  = 1'b1;
            pass_d  = (err_d == 5'd0);
            state_d = ST_FINISH;
          end else begin
            vec_d   = vec_q + 4'd1;
            cnt_d   = DWELL - 4'd1;
            state_d = ST_SETTLE;
          end
        end else begin
          eval_y_d = gate_y;
          ack_d    = 1'b1;
          state_d  = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      sweep_q  <= 1'b0;
      vec_q    <= 4'd0;
      tt_q     <= 16'd0;
      err_q    <= 5'd0;
      pass_q   <= 1'b0;
      eval_y_q <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sweep_q  <= sweep_d;
      vec_q    <= vec_d;
      tt_q     <= tt_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      eval_y_q <= eval_y_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign eval_ack = ack_q;
  assign eval_y   = eval_y_q;
  assign vec_o    = vec_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tt_o     = tt_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;

endmodule
